// File: rtl/key_cfg_pkg.sv
// Shared definitions for the front-panel configuration controller:
// FSM state encodings, key identifiers and default timing constants.
package key_cfg_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE     = 3'd0;
   localparam state_t ST_APPLY    = 3'd1;
   localparam state_t ST_HOLD     = 3'd2;
   localparam state_t ST_REPEAT   = 3'd3;
   localparam state_t ST_WAIT_REL = 3'd4;

   localparam logic [1:0] KEY_MODE = 2'd0;
   localparam logic [1:0] KEY_UP   = 2'd1;
   localparam logic [1:0] KEY_DOWN = 2'd2;

   // Defaults assume a 50 MHz system clock
   localparam logic [19:0] DEB_MAX_DEF  = 20'd999_999;
   localparam logic [24:0] HOLD_MAX_DEF = 25'd24_999_999;
   localparam logic [22:0] REP_MAX_DEF  = 23'd4_999_999;

endpackage

// File: rtl/key_debounce_lvl.sv
// Synchronises one active-low raw button and debounces it into a stable
// level plus a single-cycle press pulse on each debounced 1->0 transition.
module key_debounce_lvl
   import key_cfg_pkg::*;
#(
   parameter logic [19:0] DEB_MAX = DEB_MAX_DEF
)(
   input  logic clk,
   input  logic rst,
   input  logic key_raw,
   output logic level,
   output logic press
);

   logic [1:0]  sync_q;
   logic [19:0] cnt;
   logic        level_d;
   logic        sync;

   assign sync = sync_q[1];

   // Sync FFs reset to released so a key held across reset re-debounces
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], key_raw};
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt     <= '0;
         level   <= 1'b1;
         level_d <= 1'b1;
      end else begin
         level_d <= level;
         if (sync == level) begin
            cnt <= '0;
         end else if (cnt == DEB_MAX) begin
            level <= sync;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 20'd1;
         end
      end
   end

   assign press = level_d & ~level;

endmodule

// File: rtl/key_cfg_ctrl.sv
// Front-panel key controller: arbitrates debounced MODE/UP/DOWN presses and
// sequences press, long-press and auto-repeat actions into mode/threshold.
module key_cfg_ctrl
   import key_cfg_pkg::*;
#(
   parameter int              NUM_MODES = 4,
   parameter int              MODE_W    = 2,
   parameter logic [19:0]     DEB_MAX   = DEB_MAX_DEF,
   parameter logic [24:0]     HOLD_MAX  = HOLD_MAX_DEF,
   parameter logic [22:0]     REP_MAX   = REP_MAX_DEF,
   parameter int              THR_W     = 8,
   parameter logic [THR_W-1:0] THR_DEF  = THR_W'(128),
   parameter logic [THR_W-1:0] THR_STEP = THR_W'(1)
)(
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic              key_mode,
   input  logic              key_up,
   input  logic              key_down,
   output logic [MODE_W-1:0] mode,
   output logic [THR_W-1:0]  threshold,
   output logic              cfg_valid,
   output logic              busy
);

   localparam logic [MODE_W-1:0] MODE_LAST = MODE_W'(NUM_MODES - 1);

   logic [2:0]        level;
   logic [2:0]        press;
   state_t            state;
   logic [1:0]        key_id;
   logic [24:0]       hold_cnt;
   logic [22:0]       rep_cnt;
   logic              released;
   logic              do_action;
   logic [THR_W:0]    thr_sum;
   logic [THR_W-1:0]  thr_up;
   logic [THR_W-1:0]  thr_dn;
   logic [MODE_W-1:0] mode_inc;
   logic [MODE_W-1:0] mode_nxt;
   logic [THR_W-1:0]  thr_nxt;

   key_debounce_lvl #(.DEB_MAX(DEB_MAX)) u_deb_mode (
      .clk(sys_clk), .rst(sys_rst), .key_raw(key_mode),
      .level(level[KEY_MODE]), .press(press[KEY_MODE])
   );

   key_debounce_lvl #(.DEB_MAX(DEB_MAX)) u_deb_up (
      .clk(sys_clk), .rst(sys_rst), .key_raw(key_up),
      .level(level[KEY_UP]), .press(press[KEY_UP])
   );

   key_debounce_lvl #(.DEB_MAX(DEB_MAX)) u_deb_down (
      .clk(sys_clk), .rst(sys_rst), .key_raw(key_down),
      .level(level[KEY_DOWN]), .press(press[KEY_DOWN])
   );

   always_comb begin
      released = level[KEY_MODE];
      case (key_id)
         KEY_UP:   released = level[KEY_UP];
         KEY_DOWN: released = level[KEY_DOWN];
         default:  released = level[KEY_MODE];
      endcase
   end

   // Release takes priority over a terminal count landing in the same cycle
   always_comb begin
      do_action = 1'b0;
      case (state)
         ST_APPLY:  do_action = 1'b1;
         ST_HOLD:   do_action = !released && (hold_cnt == HOLD_MAX);
         ST_REPEAT: do_action = !released && (rep_cnt == REP_MAX);
         default:   do_action = 1'b0;
      endcase
   end

   always_comb begin
      mode_inc = (mode == MODE_LAST) ? '0 : mode + MODE_W'(1);
      thr_sum  = {1'b0, threshold} + {1'b0, THR_STEP};
      thr_up   = thr_sum[THR_W] ? '1 : thr_sum[THR_W-1:0];
      thr_dn   = (threshold < THR_STEP) ? '0 : threshold - THR_STEP;
      mode_nxt = mode;
      thr_nxt  = threshold;
      if (do_action) begin
         case (key_id)
            KEY_MODE: mode_nxt = mode_inc;
            KEY_UP:   thr_nxt  = thr_up;
            KEY_DOWN: thr_nxt  = thr_dn;
            default:  mode_nxt = mode;
         endcase
      end
   end

   // A saturated step leaves the value unchanged and so raises no cfg_valid
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         mode      <= '0;
         threshold <= THR_DEF;
         cfg_valid <= 1'b0;
      end else begin
         mode      <= mode_nxt;
         threshold <= thr_nxt;
         cfg_valid <= (mode_nxt != mode) || (thr_nxt != threshold);
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state    <= ST_IDLE;
         key_id   <= KEY_MODE;
         hold_cnt <= '0;
         rep_cnt  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (press[KEY_MODE]) begin
                  key_id <= KEY_MODE;
                  state  <= ST_APPLY;
               end else if (press[KEY_UP]) begin
                  key_id <= KEY_UP;
                  state  <= ST_APPLY;
               end else if (press[KEY_DOWN]) begin
                  key_id <= KEY_DOWN;
                  state  <= ST_APPLY;
               end
            end
            ST_APPLY: begin
               hold_cnt <= '0;
               state    <= (key_id == KEY_MODE) ? ST_WAIT_REL : ST_HOLD;
            end
            ST_HOLD: begin
               if (released) begin
                  state <= ST_IDLE;
               end else if (hold_cnt == HOLD_MAX) begin
                  hold_cnt <= '0;
                  rep_cnt  <= '0;
                  state    <= ST_REPEAT;
               end else begin
                  hold_cnt <= hold_cnt + 25'd1;
               end
            end
            ST_REPEAT: begin
               if (released) begin
                  state <= ST_IDLE;
               end else if (rep_cnt == REP_MAX) begin
                  rep_cnt <= '0;
               end else begin
                  rep_cnt <= rep_cnt + 23'd1;
               end
            end
            ST_WAIT_REL: begin
               if (released) begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_key_cfg_ctrl.sv
// Directed bench for key_cfg_ctrl with shortened timing (DEB_MAX=4,
// HOLD_MAX=20, REP_MAX=5); expected values are hand-computed per step.
module tb_key_cfg_ctrl;

   logic       sys_clk;
   logic       sys_rst;
   logic [2:0] keys_n;
   logic [1:0] mode;
   logic [7:0] threshold;
   logic       cfg_valid;
   logic       busy;

   int compared   = 0;
   int mismatched = 0;
   int pulse_cnt  = 0;
   int base       = 0;

   key_cfg_ctrl #(
      .NUM_MODES(4), .MODE_W(2),
      .DEB_MAX(20'd4), .HOLD_MAX(25'd20), .REP_MAX(23'd5),
      .THR_W(8), .THR_DEF(8'd128), .THR_STEP(8'd1)
   ) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .key_mode(keys_n[0]), .key_up(keys_n[1]), .key_down(keys_n[2]),
      .mode(mode), .threshold(threshold), .cfg_valid(cfg_valid), .busy(busy)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   always @(negedge sys_clk) begin
      if (cfg_valid === 1'b1) pulse_cnt++;
   end

   task automatic step(input int n);
      repeat (n) @(negedge sys_clk);
   endtask

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic apply_stimulus(input int key, input int cycles);
      keys_n[key] = 1'b0;
      step(cycles);
      keys_n[key] = 1'b1;
   endtask

   task automatic wait_idle(input string tag);
      int n;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin
         step(1);
         n++;
      end
      check_output(tag, {31'd0, busy}, 32'd0);
      step(3);
   endtask

   initial begin
      keys_n  = 3'b111;
      sys_rst = 1'b1;
      step(3);
      sys_rst = 1'b0;
      step(2);

      // Reset state
      check_output("rst_mode", mode, 0);
      check_output("rst_thr", threshold, 128);
      check_output("rst_cfg", cfg_valid, 0);
      check_output("rst_busy", busy, 0);

      // MODE press: update lands 2+5+1+1 = 9 edges after the raw edge
      base = pulse_cnt;
      keys_n[0] = 1'b0;
      step(8);
      check_output("lat_mode_before", mode, 0);
      check_output("lat_busy", busy, 1);
      step(1);
      check_output("lat_mode_after", mode, 1);
      check_output("lat_cfg", cfg_valid, 1);
      step(1);
      check_output("cfg_one_cycle", cfg_valid, 0);
      step(20);
      keys_n[0] = 1'b1;
      wait_idle("mode1_idle");
      check_output("mode1_pulses", pulse_cnt - base, 1);
      apply_stimulus(0, 30);
      wait_idle("mode2_idle");
      check_output("mode2", mode, 2);
      apply_stimulus(0, 30);
      wait_idle("mode3_idle");
      check_output("mode3", mode, 3);
      apply_stimulus(0, 30);
      wait_idle("mode_wrap_idle");
      check_output("mode_wrap", mode, 0);
      check_output("mode_pulses", pulse_cnt - base, 4);

      // UP glitch rejected, then a short press
      base = pulse_cnt;
      apply_stimulus(1, 3);
      step(15);
      check_output("glitch_thr", threshold, 128);
      check_output("glitch_busy", busy, 0);
      check_output("glitch_pulses", pulse_cnt - base, 0);
      apply_stimulus(1, 10);
      step(3);
      check_output("short_busy", busy, 1);
      wait_idle("short_idle");
      check_output("short_thr", threshold, 129);
      check_output("short_pulses", pulse_cnt - base, 1);

      // UP held 60 cycles: steps at edges 9, 30, then 36,42,...,66
      base = pulse_cnt;
      keys_n[1] = 1'b0;
      step(29);
      check_output("hold_pre_tc", threshold, 130);
      step(1);
      check_output("hold_tc", threshold, 131);
      step(30);
      keys_n[1] = 1'b1;
      wait_idle("repeat_idle");
      check_output("repeat_thr", threshold, 137);
      check_output("repeat_pulses", pulse_cnt - base, 8);

      // Saturate at 255, then press UP again with no effect
      base = pulse_cnt;
      apply_stimulus(1, 800);
      wait_idle("sat_hi_idle");
      check_output("sat_hi_thr", threshold, 255);
      check_output("sat_hi_pulses", pulse_cnt - base, 118);
      base = pulse_cnt;
      apply_stimulus(1, 10);
      step(3);
      check_output("sat_hi_busy", busy, 1);
      wait_idle("sat_hi2_idle");
      check_output("sat_hi2_thr", threshold, 255);
      check_output("sat_hi2_pulses", pulse_cnt - base, 0);

      // Drive down to 0, then hold DOWN through repeat with no effect
      base = pulse_cnt;
      apply_stimulus(2, 1700);
      wait_idle("sat_lo_idle");
      check_output("sat_lo_thr", threshold, 0);
      check_output("sat_lo_pulses", pulse_cnt - base, 255);
      base = pulse_cnt;
      apply_stimulus(2, 60);
      wait_idle("sat_lo2_idle");
      check_output("sat_lo2_thr", threshold, 0);
      check_output("sat_lo2_pulses", pulse_cnt - base, 0);

      // MODE and UP together: MODE wins, UP dropped
      base = pulse_cnt;
      keys_n[0] = 1'b0;
      keys_n[1] = 1'b0;
      step(30);
      keys_n = 3'b111;
      wait_idle("prio_idle");
      check_output("prio_mode", mode, 1);
      check_output("prio_thr", threshold, 0);
      check_output("prio_pulses", pulse_cnt - base, 1);

      // DOWN pressed while UP is being serviced is ignored
      base = pulse_cnt;
      keys_n[1] = 1'b0;
      step(10);
      keys_n[2] = 1'b0;
      step(8);
      keys_n[2] = 1'b1;
      step(2);
      keys_n[1] = 1'b1;
      wait_idle("busy_ign_idle");
      step(10);
      check_output("busy_ign_thr", threshold, 1);
      check_output("busy_ign_pulses", pulse_cnt - base, 1);
      check_output("busy_ign_busy", busy, 0);

      // Reset mid-REPEAT, key still held afterwards re-debounces
      keys_n[1] = 1'b0;
      step(40);
      check_output("pre_rst_thr", threshold, 4);
      sys_rst = 1'b1;
      #1;
      check_output("mid_rst_mode", mode, 0);
      check_output("mid_rst_thr", threshold, 128);
      check_output("mid_rst_busy", busy, 0);
      check_output("mid_rst_cfg", cfg_valid, 0);
      step(3);
      sys_rst = 1'b0;
      step(8);
      check_output("post_rst_before", threshold, 128);
      check_output("post_rst_busy", busy, 1);
      step(1);
      check_output("post_rst_after", threshold, 129);
      step(1);
      keys_n[1] = 1'b1;
      wait_idle("post_rst_idle");
      check_output("post_rst_thr", threshold, 129);
      check_output("post_rst_mode", mode, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
